// File: rtl/dram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dram_arbiter_pkg
//   Shared definitions for the DRAM arbiter slice: the SDRAM command bus widths
//   and the command record held in the arbiter's output register.
// -----------------------------------------------------------------------------
package dram_arbiter_pkg;

  localparam int DRAM_ADDR_W = 24;
  localparam int DRAM_DATA_W = 16;

  typedef struct packed {
    logic                   we;
    logic [DRAM_ADDR_W-1:0] addr;
    logic [DRAM_DATA_W-1:0] wdata;
  } dram_cmd_t;

endpackage

// File: rtl/dram_arbiter_tag_fifo.sv
// -----------------------------------------------------------------------------
// tag_fifo
//   Small synchronous FIFO that remembers which requester issued each
//   outstanding read so in-order read data can be routed back.
//   DEPTH must be a power of two; the pointers wrap by natural overflow.
//
// Ports
//   clk_200 : clock
//   rst     : synchronous active-high reset (count and pointers to 0)
//   push    : write din (ignored when full)
//   din     : tag to store
//   pop     : discard the head entry (ignored when empty)
//   dout    : head entry, valid while empty is low
//   count   : number of stored entries, 0..DEPTH
//   empty   : count == 0
//   full    : count == DEPTH
// -----------------------------------------------------------------------------
module tag_fifo #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_200,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (here unconditionally), otherwise synthesis infers a latch.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    // Simultaneous push and pop cancel out.
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values; blocking here creates order races.
  always_ff @(posedge clk_200) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count guards every read, and
  // a reset on the array would force flops instead of a RAM/LUT structure.
  always_ff @(posedge clk_200) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
//   Arbitrates N_REQ requesters onto one SDRAM controller command port.
//   Requester 0 (VGA framebuffer) normally wins, but requesters 1..N_REQ-1
//   that have waited MAX_WAIT cycles jump ahead of it. Ties among aged, and
//   among non-aged, requesters are broken round-robin. Reads are tagged with
//   the requester index so in-order read data is returned to its owner.
//
// Ports
//   clk_200, rst        : clock, synchronous active-high reset
//   req_valid/we/addr/wdata [N_REQ] : per-requester command
//   req_ready [N_REQ]   : command accepted this cycle (one-hot or zero)
//   rsp_valid [N_REQ]   : one-cycle read-data strobe for the owning requester
//   rsp_rdata           : shared read data bus
//   ctl_valid/ready/we/addr/wdata   : command to the SDRAM controller
//   ctl_rvalid/rdata    : in-order read data from the controller
//   err_underflow       : sticky, read data arrived with no outstanding tag
// -----------------------------------------------------------------------------
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int MAX_WAIT  = 64,
  parameter int TAG_DEPTH = 8
) (
  input  logic                              clk_200,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ-1:0]                  req_we,
  input  logic [N_REQ-1:0][DRAM_ADDR_W-1:0] req_addr,
  input  logic [N_REQ-1:0][DRAM_DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]                  req_ready,
  output logic [N_REQ-1:0]                  rsp_valid,
  output logic [DRAM_DATA_W-1:0]            rsp_rdata,
  output logic                              ctl_valid,
  input  logic                              ctl_ready,
  output logic                              ctl_we,
  output logic [DRAM_ADDR_W-1:0]            ctl_addr,
  output logic [DRAM_DATA_W-1:0]            ctl_wdata,
  input  logic                              ctl_rvalid,
  input  logic [DRAM_DATA_W-1:0]            ctl_rdata,
  output logic                              err_underflow
);

  localparam int TAG_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int CNT_W  = $clog2(TAG_DEPTH) + 1;

  dram_cmd_t                         cmd_q, cmd_d;
  logic                              ctl_valid_q, ctl_valid_d;
  logic [N_REQ-1:1][WAIT_W-1:0]      wait_q, wait_d;
  logic [TAG_W-1:0]                  rr_q, rr_d;
  logic [N_REQ-1:0]                  rsp_valid_q, rsp_valid_d;
  logic [DRAM_DATA_W-1:0]            rsp_rdata_q, rsp_rdata_d;
  logic                              err_q, err_d;

  logic [N_REQ-1:0]                  eligible, aged_cand, young_cand;
  logic [TAG_W:0]                    aged_pick, young_pick;
  logic [TAG_W-1:0]                  grant_idx;
  logic                              grant_rr, accept, slot_free;

  logic                              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [TAG_W-1:0]                  fifo_dout;
  logic [CNT_W-1:0]                  fifo_count;

  // Round-robin search over cand starting just after last; index 0 is never a
  // candidate. Returns {found, index}. Iterating far-to-near lets the nearest
  // match overwrite the others, so no early exit is needed.
  function automatic logic [TAG_W:0] rr_pick(input logic [N_REQ-1:0] cand,
                                             input logic [TAG_W-1:0] last);
    logic [TAG_W:0] res;
    int             idx;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      if (cand[TAG_W'(idx)]) res = {1'b1, TAG_W'(idx)};
    end
    return res;
  endfunction

  // Grant selection. Read eligibility uses the registered FIFO count, so a
  // read return in the same cycle cannot unblock a read.
  always_comb begin
    eligible   = req_valid & (req_we | {N_REQ{~fifo_full}});
    aged_cand  = '0;
    young_cand = '0;
    for (int i = 1; i < N_REQ; i++) begin
      aged_cand[i]  = eligible[i] && (wait_q[i] == WAIT_W'(MAX_WAIT));
      young_cand[i] = eligible[i] && (wait_q[i] != WAIT_W'(MAX_WAIT));
    end
    aged_pick  = rr_pick(aged_cand, rr_q);
    young_pick = rr_pick(young_cand, rr_q);

    // The command register can take a new entry if it is empty or draining.
    slot_free = !ctl_valid_q || ctl_ready;

    grant_idx = '0;
    grant_rr  = 1'b0;
    accept    = 1'b0;
    if (aged_pick[TAG_W]) begin
      grant_idx = aged_pick[TAG_W-1:0];
      grant_rr  = 1'b1;
      accept    = 1'b1;
    end else if (eligible[0]) begin
      accept    = 1'b1;
    end else if (young_pick[TAG_W]) begin
      grant_idx = young_pick[TAG_W-1:0];
      grant_rr  = 1'b1;
      accept    = 1'b1;
    end
    accept = accept && slot_free && !rst;

    req_ready            = '0;
    req_ready[grant_idx] = accept;
  end

  // Next-state for command register, aging, round-robin and response path.
  always_comb begin
    cmd_d       = cmd_q;
    ctl_valid_d = ctl_valid_q && !ctl_ready;
    if (accept) begin
      cmd_d = '{we:    req_we[grant_idx],
                addr:  req_addr[grant_idx],
                wdata: req_wdata[grant_idx]};
      ctl_valid_d = 1'b1;
    end

    rr_d = (accept && grant_rr) ? grant_idx : rr_q;

    // Aging: count while waiting, saturate, clear on acceptance or idle.
    for (int i = 1; i < N_REQ; i++) begin
      if (req_valid[i] && !req_ready[i]) begin
        wait_d[i] = (wait_q[i] == WAIT_W'(MAX_WAIT)) ? wait_q[i]
                                                     : wait_q[i] + WAIT_W'(1);
      end else begin
        wait_d[i] = '0;
      end
    end

    fifo_push = accept && !req_we[grant_idx];
    fifo_pop  = ctl_rvalid;

    // Read data with no outstanding tag is dropped and flagged.
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    err_d       = err_q || (ctl_rvalid && fifo_empty);
    if (ctl_rvalid && !fifo_empty) begin
      rsp_valid_d[fifo_dout] = 1'b1;
      rsp_rdata_d            = ctl_rdata;
    end
  end

  always_ff @(posedge clk_200) begin
    if (rst) begin
      cmd_q       <= '0;
      ctl_valid_q <= 1'b0;
      wait_q      <= '0;
      rr_q        <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      ctl_valid_q <= ctl_valid_d;
      wait_q      <= wait_d;
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
    end
  end

  tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_200 (clk_200),
    .rst     (rst),
    .push    (fifo_push),
    .din     (grant_idx),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Reads are only granted below TAG_DEPTH, so the count can never exceed it.
  a_count_bound: assert property (@(posedge clk_200) disable iff (rst)
                                  fifo_count <= CNT_W'(TAG_DEPTH));

  assign ctl_valid     = ctl_valid_q;
  assign ctl_we        = cmd_q.we;
  assign ctl_addr      = cmd_q.addr;
  assign ctl_wdata     = cmd_q.wdata;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;
  import dram_arbiter_pkg::*;

  typedef struct packed {
    logic [2:0]  vec;
    logic [15:0] data;
  } rsp_t;

  logic             clk_200 = 1'b0;
  logic             rst;
  logic [2:0]       req_valid, req_we, req_ready, rsp_valid;
  logic [2:0][23:0] req_addr;
  logic [2:0][15:0] req_wdata;
  logic [15:0]      rsp_rdata, ctl_wdata, ctl_rdata;
  logic [23:0]      ctl_addr;
  logic             ctl_valid, ctl_ready, ctl_we, ctl_rvalid, err_underflow;

  int n_cmp = 0;
  int n_err = 0;

  dram_cmd_t exp_ctl[$];
  rsp_t      exp_rsp[$];

  always #5 clk_200 = ~clk_200;

  dram_arbiter dut (
    .clk_200       (clk_200),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .ctl_valid     (ctl_valid),
    .ctl_ready     (ctl_ready),
    .ctl_we        (ctl_we),
    .ctl_addr      (ctl_addr),
    .ctl_wdata     (ctl_wdata),
    .ctl_rvalid    (ctl_rvalid),
    .ctl_rdata     (ctl_rdata),
    .err_underflow (err_underflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [63:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected output 0x%0h with nothing expected", name, act);
  endtask

  function automatic dram_cmd_t mk_cmd(input logic we, input logic [23:0] a, input logic [15:0] d);
    return '{we: we, addr: a, wdata: d};
  endfunction

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [23:0] a, input logic [15:0] d);
    req_valid[i] = v;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_wdata[i] = d;
  endtask

  task automatic tick();
    @(posedge clk_200);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Monitor: every command transfer and every read response is compared
  // against the scoreboard queues, mid-cycle.
  always @(negedge clk_200) begin
    dram_cmd_t ec;
    rsp_t      er;
    if (ctl_valid && ctl_ready) begin
      if (exp_ctl.size() == 0) begin
        fail_unexpected("ctl_unexpected", {ctl_we, ctl_addr, ctl_wdata});
      end else begin
        ec = exp_ctl.pop_front();
        check("ctl_cmd", {ctl_we, ctl_addr, ctl_wdata}, ec);
      end
    end
    if (rsp_valid != 3'b000) begin
      if (exp_rsp.size() == 0) begin
        fail_unexpected("rsp_unexpected", {rsp_valid, rsp_rdata});
      end else begin
        er = exp_rsp.pop_front();
        check("rsp_vec", rsp_valid, er.vec);
        check("rsp_data", rsp_rdata, er.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] c_exp [4];
    c_exp = '{3'b100, 3'b010, 3'b100, 3'b010};

    rst        = 1'b1;
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    ctl_ready  = 1'b0;
    ctl_rvalid = 1'b0;
    ctl_rdata  = '0;
    tick();
    tick();

    // ---- reset state; requests during reset are not accepted
    req_valid = 3'b111;
    req_we    = 3'b111;
    settle();
    check("rst_req_ready", req_ready, 3'b000);
    tick();
    check("rst_ctl_valid", ctl_valid, 1'b0);
    check("rst_ctl_we", ctl_we, 1'b0);
    check("rst_ctl_addr", ctl_addr, 24'h0);
    check("rst_ctl_wdata", ctl_wdata, 16'h0);
    check("rst_rsp_valid", rsp_valid, 3'b000);
    check("rst_rsp_rdata", rsp_rdata, 16'h0);
    check("rst_err", err_underflow, 1'b0);
    req_valid = '0;
    req_we    = '0;
    rst       = 1'b0;
    ctl_ready = 1'b1;
    tick();

    // ---- single read from requester 1
    set_req(1, 1'b1, 1'b0, 24'h000100, 16'h0000);
    settle();
    check("a_ready", req_ready, 3'b010);
    check("a_ctl_idle", ctl_valid, 1'b0);
    exp_ctl.push_back(mk_cmd(1'b0, 24'h000100, 16'h0000));
    tick();
    req_valid[1] = 1'b0;
    settle();
    check("a_ctl_valid", ctl_valid, 1'b1);
    check("a_ctl_addr", ctl_addr, 24'h000100);
    check("a_ctl_we", ctl_we, 1'b0);
    tick();
    ctl_rvalid = 1'b1;
    ctl_rdata  = 16'hBEEF;
    exp_rsp.push_back('{vec: 3'b010, data: 16'hBEEF});
    settle();
    check("a_rsp_early", rsp_valid, 3'b000);
    tick();
    ctl_rvalid = 1'b0;
    settle();
    check("a_rsp_valid", rsp_valid, 3'b010);
    check("a_rsp_rdata", rsp_rdata, 16'hBEEF);
    tick();
    check("a_rsp_pulse", rsp_valid, 3'b000);

    // ---- priority and aging: 0 wins 64 times, then aged 1 once, then 0
    set_req(0, 1'b1, 1'b1, 24'hA00000, 16'h0A0A);
    set_req(1, 1'b1, 1'b1, 24'hA11111, 16'h1A1A);
    for (int k = 0; k < 66; k++) begin
      settle();
      if (k == 64) begin
        check($sformatf("b_grant%0d", k), req_ready, 3'b010);
        exp_ctl.push_back(mk_cmd(1'b1, 24'hA11111, 16'h1A1A));
      end else begin
        check($sformatf("b_grant%0d", k), req_ready, 3'b001);
        exp_ctl.push_back(mk_cmd(1'b1, 24'hA00000, 16'h0A0A));
      end
      tick();
    end
    req_valid = '0;
    tick();

    // ---- round-robin between 1 and 2 (last grant was 1, so 2 goes first)
    set_req(1, 1'b1, 1'b1, 24'hC11111, 16'h1C1C);
    set_req(2, 1'b1, 1'b1, 24'hC22222, 16'h2C2C);
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("c_rr%0d", k), req_ready, c_exp[k]);
      if (c_exp[k] == 3'b100) exp_ctl.push_back(mk_cmd(1'b1, 24'hC22222, 16'h2C2C));
      else                    exp_ctl.push_back(mk_cmd(1'b1, 24'hC11111, 16'h1C1C));
      tick();
    end
    req_valid = '0;
    tick();

    // ---- tag FIFO full: 8 reads, then reads blocked while writes pass
    set_req(1, 1'b1, 1'b0, 24'h000200, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      settle();
      check($sformatf("d_fill%0d", k), req_ready, 3'b010);
      exp_ctl.push_back(mk_cmd(1'b0, 24'h000200, 16'h0000));
      tick();
    end
    set_req(2, 1'b1, 1'b1, 24'h222222, 16'h2222);
    settle();
    check("d_full_write", req_ready, 3'b100);
    exp_ctl.push_back(mk_cmd(1'b1, 24'h222222, 16'h2222));
    tick();
    req_valid[2] = 1'b0;
    settle();
    check("d_full_block", req_ready, 3'b000);
    tick();
    ctl_rvalid = 1'b1;
    ctl_rdata  = 16'h1111;
    exp_rsp.push_back('{vec: 3'b010, data: 16'h1111});
    settle();
    check("d_pop_same_cycle", req_ready, 3'b000);
    tick();
    ctl_rvalid = 1'b0;
    settle();
    check("d_unblock", req_ready, 3'b010);
    exp_ctl.push_back(mk_cmd(1'b0, 24'h000200, 16'h0000));
    tick();
    req_valid[1] = 1'b0;
    // drain 5 of the 8 outstanding tags, leaving 3
    for (int k = 0; k < 5; k++) begin
      ctl_rvalid = 1'b1;
      ctl_rdata  = 16'(16'h2000 + k);
      exp_rsp.push_back('{vec: 3'b010, data: 16'(16'h2000 + k)});
      tick();
    end
    ctl_rvalid = 1'b0;
    tick();
    tick();

    // ---- backpressure with a write pending
    ctl_ready = 1'b0;
    set_req(2, 1'b1, 1'b1, 24'h333333, 16'h3333);
    settle();
    check("e_accept_empty", req_ready, 3'b100);
    exp_ctl.push_back(mk_cmd(1'b1, 24'h333333, 16'h3333));
    tick();
    req_addr[2]  = 24'h444444;
    req_wdata[2] = 16'h4444;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("e_hold_valid%0d", k), ctl_valid, 1'b1);
      check($sformatf("e_hold_addr%0d", k), ctl_addr, 24'h333333);
      check($sformatf("e_hold_wdata%0d", k), ctl_wdata, 16'h3333);
      check($sformatf("e_no_ready%0d", k), req_ready, 3'b000);
      tick();
    end
    ctl_ready = 1'b1;
    settle();
    check("e_transfer_accept", req_ready, 3'b100);
    exp_ctl.push_back(mk_cmd(1'b1, 24'h444444, 16'h4444));
    tick();
    req_valid[2] = 1'b0;
    settle();
    check("e_next_addr", ctl_addr, 24'h444444);
    tick();
    tick();

    // ---- reset with a pending command and 3 outstanding reads
    check("f_err_before", err_underflow, 1'b0);
    ctl_ready = 1'b0;
    set_req(1, 1'b1, 1'b1, 24'h555555, 16'h5555);
    settle();
    check("f_pend_accept", req_ready, 3'b010);
    tick();
    req_valid[1] = 1'b0;
    rst          = 1'b1;
    settle();
    check("f_pending", ctl_valid, 1'b1);
    tick();
    rst       = 1'b0;
    ctl_ready = 1'b1;
    settle();
    check("f_discard", ctl_valid, 1'b0);
    check("f_err_cleared", err_underflow, 1'b0);
    tick();
    ctl_rvalid = 1'b1;
    ctl_rdata  = 16'hDEAD;
    tick();
    ctl_rvalid = 1'b0;
    settle();
    check("f_err_set", err_underflow, 1'b1);
    check("f_no_rsp", rsp_valid, 3'b000);
    tick();
    check("f_err_sticky", err_underflow, 1'b1);
    check("f_no_rsp_late", rsp_valid, 3'b000);
    tick();
    tick();

    check("ctl_queue_drained", exp_ctl.size(), 0);
    check("rsp_queue_drained", exp_rsp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3: number of requesters; index 0 is the VGA framebuffer port.
REQ-002 SHALL have parameter MAX_WAIT, default 64: aging threshold in cycles for requesters 1..N_REQ-1.
REQ-003 SHALL have parameter TAG_DEPTH, default 8: number of outstanding reads (power of two).
REQ-004 SHALL have ports clk_200 (input, 1, sole clock) and rst (input, 1; synchronous, active-high).
REQ-005 SHALL have ports req_valid (input, N_REQ), req_we (input, N_REQ), req_addr (input, N_REQ x 24) and req_wdata (input, N_REQ x 16): per-requester command.
REQ-006 SHALL have ports req_ready (output, N_REQ: command accepted this cycle), rsp_valid (output, N_REQ) and rsp_rdata (output, 16: read data, shared bus).
REQ-007 SHALL have ports ctl_valid (output, 1), ctl_ready (input, 1), ctl_we (output, 1), ctl_addr (output, 24) and ctl_wdata (output, 16): command to the SDRAM controller.
REQ-008 SHALL have ports ctl_rvalid (input, 1) and ctl_rdata (input, 16): in-order read return from the controller.
REQ-009 SHALL have output err_underflow (1): sticky flag set by a read return with no outstanding tag.

Function
REQ-010 A command SHALL transfer on a requester port when req_valid[i] and req_ready[i] are both high; at most one req_ready bit SHALL be high per cycle.
REQ-011 Output stage: a one-entry command register; a requester command SHALL be accepted when the register is empty or ctl_valid and ctl_ready are both high in the same cycle.
REQ-012 ctl_valid SHALL rise in the cycle after acceptance (latency 1) and hold, with ctl_we/ctl_addr/ctl_wdata stable, until ctl_ready is high.
REQ-013 Priority, highest first:
  - (a) aged requesters (1..N_REQ-1 with wait counter at MAX_WAIT);
  - (b) requester 0;
  - (c) non-aged requesters 1..N_REQ-1.
REQ-014 Within tier (a) and within tier (c), selection SHALL be round-robin starting after the last granted index; the pointer SHALL update only on an accepted grant from tier (a) or (c).
REQ-015 Wait counters for requesters 1..N_REQ-1 SHALL behave as follows:
  - increment each cycle req_valid is high and the port is not accepted;
  - saturate at MAX_WAIT;
  - clear on acceptance or when req_valid is low.
REQ-016 A read SHALL be eligible for grant only if the tag FIFO count is below TAG_DEPTH, evaluated on the registered count; a same-cycle pop SHALL NOT unblock it.
REQ-017 Writes SHALL be eligible regardless of FIFO occupancy.
REQ-018 An ineligible requester SHALL be skipped and SHALL keep aging.
REQ-019 Each accepted read SHALL push its requester index into the tag FIFO in the acceptance cycle.
REQ-020 Each ctl_rvalid pulse SHALL pop one tag and, in the next cycle, drive rsp_valid[tag]=1 and rsp_rdata=ctl_rdata for one cycle.
REQ-021 A simultaneous push and pop SHALL leave the count unchanged.
REQ-022 The FIFO pointers SHALL wrap modulo TAG_DEPTH.
REQ-023 A ctl_rvalid pulse with the FIFO empty SHALL set err_underflow, drop the data, produce no rsp_valid and leave the count at 0.
REQ-024 Writes SHALL produce no response.
REQ-025 Requesters SHALL hold command fields stable while req_valid is high; the arbiter SHALL NOT check this.

Reset
REQ-026 While rst is high at a clk_200 edge, the following SHALL be cleared:
  - command register emptied (ctl_valid=0);
  - req_ready=0 and rsp_valid=0;
  - tag FIFO count=0 and pointers=0;
  - all wait counters=0;
  - round-robin pointer=0 and err_underflow=0.
REQ-027 ctl_addr, ctl_wdata, ctl_we and rsp_rdata SHALL reset to 0.
REQ-028 Reset mid-transaction SHALL discard the pending command and all outstanding tags.
REQ-029 Read returns arriving after reset SHALL set err_underflow.

Structure
REQ-030 The shared package pkg SHALL hold DRAM_ADDR_W=24, DRAM_DATA_W=16 and typedef dram_cmd_t (we, addr, wdata).
REQ-031 The tag FIFO SHALL be a sub-module tag_fifo (parameterised width/depth, synchronous reset, push/pop/count/empty/full).
REQ-032 The arbiter SHALL contain no other sub-modules.

Verification
REQ-033 Single read: requester 1 reads addr 0x000100 with ctl_ready=1 -> ctl_valid in the next cycle with addr 0x000100 and ctl_we=0; ctl_rvalid with 0xBEEF -> rsp_valid[1]=1 and rsp_rdata=0xBEEF one cycle later.
REQ-034 Priority/aging: requesters 0 and 1 both valid continuously with ctl_ready=1 -> requester 0 granted for 64 cycles, then requester 1 granted exactly once, then requester 0 again.
REQ-035 Round-robin: requesters 1 and 2 valid continuously, requester 0 idle -> grants alternate 1,2,1,2; no port waits more than 1 accept.
REQ-036 Tag full: 8 reads accepted with no returns -> ninth read not granted while a write from another port is granted; one ctl_rvalid -> read granted in the following cycle.
REQ-037 Backpressure: ctl_ready=0 for 5 cycles with a write pending -> ctl fields stable and no further req_ready; ctl_ready=1 -> transfer plus a new acceptance in the same cycle.
REQ-038 Underflow/reset: assert rst with 3 reads outstanding, then 1 ctl_rvalid -> err_underflow=1 and no rsp_valid.
